// File: rtl/cargador_entradas_pkg.sv
// Shared widths and FSM encoding for the entry loader that feeds the hash miner.
// Optional checksum byte per entry is enabled by defining CARGADOR_CHECKSUM_EN.
package cargador_entradas_pkg;

    localparam int ENT_BYTES = 12;
    localparam int ENT_W     = 8 * ENT_BYTES;
    localparam int NUM_ENT   = 4;
    localparam int PTR_W     = 2;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } estado_e;

endpackage

// File: rtl/cargador_entradas_ensamblador_bytes.sv
// Byte counter and shift register building one 96-bit entry MSB-first.
// CARGADOR_CHECKSUM_EN adds a 13th XOR byte per entry, checked on arrival.
module ensamblador_bytes
    import cargador_entradas_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             take_i,
    input  logic             flush_i,
    input  logic [7:0]       byte_i,
    output logic [ENT_W-1:0] word_o,
    output logic             done_o,
    output logic             chk_ok_o
);

`ifdef CARGADOR_CHECKSUM_EN
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ENT_BYTES);
`else
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ENT_BYTES - 1);
`endif

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ENT_W-1:0] word_q, word_d;
    logic [7:0]       acc_q, acc_d;
    logic             data_byte;

    assign done_o = take_i && (cnt_q == LAST);

`ifdef CARGADOR_CHECKSUM_EN
    // The checksum byte is compared, never shifted into the entry.
    assign data_byte = take_i && !done_o;
    assign word_o    = word_q;
    assign chk_ok_o  = (acc_q == byte_i);
`else
    assign data_byte = take_i;
    assign word_o    = {word_q[ENT_W-9:0], byte_i};
    assign chk_ok_o  = 1'b1;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        acc_d  = acc_q;
        if (data_byte) begin
            word_d = {word_q[ENT_W-9:0], byte_i};
            acc_d  = acc_q ^ byte_i;
        end
        if (flush_i || done_o) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (take_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            word_q <= '0;
            acc_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/cargador_entradas.sv
// Entry loader: byte stream in, up to four 96-bit entries out via a registered read port.
// Define CARGADOR_CHECKSUM_EN to require an XOR checksum byte after each entry.
module cargador_entradas
    import cargador_entradas_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             byte_last,
    output logic             byte_ready,
    input  logic             clear,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [ENT_W-1:0] entrada,
    output logic [PTR_W-1:0] num_entradas,
    output logic             listo,
    output logic             error
);

    estado_e          state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] num_q, num_d;
    logic             has_q, has_d;
    logic             err_q, err_d;
    logic [ENT_W-1:0] mem_q [NUM_ENT];
    logic [ENT_W-1:0] rd_q;

    logic             xfer;
    logic             flush;
    logic             done;
    logic             chk_ok;
    logic             commit;
    logic [ENT_W-1:0] word;

    // clear wins over a same-cycle byte, so the byte is refused outright.
    assign byte_ready = !reset && !clear && (state_q != DONE);
    assign xfer       = byte_valid && byte_ready;
    assign flush      = clear || (xfer && byte_last);
    assign commit     = done && chk_ok;

    ensamblador_bytes u_ens (
        .clk      (clk),
        .reset    (reset),
        .take_i   (xfer),
        .flush_i  (flush),
        .byte_i   (byte_in),
        .word_o   (word),
        .done_o   (done),
        .chk_ok_o (chk_ok)
    );

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        num_d    = num_q;
        has_d    = has_q;
        err_d    = err_q;
        if (clear) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            num_d    = '0;
            has_d    = 1'b0;
            err_d    = 1'b0;
        end else if (xfer) begin
            state_d = RECV;
            if (commit) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                has_d    = 1'b1;
            end
            if (byte_last) begin
                if (commit) begin
                    state_d = DONE;
                    num_d   = wr_ptr_q;
                end else begin
                    err_d = 1'b1;
                    if (has_q) begin
                        state_d = DONE;
                        num_d   = wr_ptr_q - PTR_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end else if (commit && wr_ptr_q == PTR_W'(NUM_ENT - 1)) begin
                // Slots full with no end of frame: keep what fits, flag truncation.
                state_d = DONE;
                num_d   = wr_ptr_q;
                err_d   = 1'b1;
            end else if (done && !chk_ok) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            num_q    <= '0;
            has_q    <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= '0;
            for (int i = 0; i < NUM_ENT; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            num_q    <= num_d;
            has_q    <= has_d;
            err_q    <= err_d;
            if (commit) begin
                mem_q[wr_ptr_q] <= word;
            end
            rd_q <= mem_q[rd_ptr];
        end
    end

    assign entrada      = rd_q;
    assign num_entradas = num_q;
    assign listo        = (state_q == DONE);
    assign error        = err_q;

endmodule
